// File: rtl/half_adder_unit.sv
`default_nettype none
// ============================================================================
// Module      : half_adder_unit
// Description : WIDTH independent single-bit half-adder lanes.
//               sum[i] = in1[i] ^ in2[i], count[i] = in1[i] & in2[i].
//               No carry travels between lanes.
//               Optional macro HALF_ADDER_REG_OUT_EN adds one output register
//               stage (async active-high reset to zero, 1-cycle latency);
//               without it the outputs are purely combinational and the
//               clock/reset ports are unused.
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder_unit #(
    parameter int WIDTH = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_count;

    // Per-lane half adder; lanes are kept separate so an X on one lane
    // cannot leak into its neighbours.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            assign w_sum[i]   = in1[i] ^ in2[i];
            assign w_count[i] = in1[i] & in2[i];
        end
    endgenerate

`ifdef HALF_ADDER_REG_OUT_EN
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_count;

    // Output register stage; reset clears results at once, without a clock.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sum   <= '0;
            r_count <= '0;
        end else begin
            r_sum   <= w_sum;
            r_count <= w_count;
        end
    end

    assign sum   = r_sum;
    assign count = r_count;
`else
    // Clock and reset have no function in the combinational build; they are
    // folded into a sink so the port list stays identical across builds.
    logic w_unused;
    assign w_unused = sys_clk ^ sys_rst;

    assign sum   = w_sum;
    assign count = w_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_half_adder_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_adder_unit
// Description : Scoreboard bench for half_adder_unit. Drives a WIDTH=1 and a
//               WIDTH=4 instance in parallel; expectations are queued at
//               stimulus time and checked by an independent monitor.
//               Follows HALF_ADDER_REG_OUT_EN to choose the output latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_adder_unit;

    logic       sys_clk;
    logic       sys_rst;
    logic       a1;
    logic       b1;
    logic       s1;
    logic       c1;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] s4;
    logic [3:0] c4;

    int n_tests;
    int n_fail;

    typedef struct {
        logic       es1;
        logic       ec1;
        logic [3:0] es4;
        logic [3:0] ec4;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    event ev_apply;

    half_adder_unit #(.WIDTH(1)) u_dut1 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .in1     (a1),
        .in2     (b1),
        .sum     (s1),
        .count   (c1)
    );

    half_adder_unit #(.WIDTH(4)) u_dut4 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .in1     (a4),
        .in2     (b4),
        .sum     (s4),
        .count   (c4)
    );

    // Clock: posedges at 5, 15, 25 ...; inputs change on negedges.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, req, $time);
        end
    endtask

    // Issue one vector to both instances and queue its expected response.
    task automatic apply(input logic ia1, input logic ib1,
                         input logic [3:0] ia4, input logic [3:0] ib4,
                         input logic es1, input logic ec1,
                         input logic [3:0] es4, input logic [3:0] ec4,
                         input string nm);
        exp_t e;
        @(negedge sys_clk);
        a1 = ia1;
        b1 = ib1;
        a4 = ia4;
        b4 = ib4;
        e.es1  = es1;
        e.ec1  = ec1;
        e.es4  = es4;
        e.ec4  = ec4;
        e.name = nm;
        sb_q.push_back(e);
        -> ev_apply;
    endtask

    // Monitor: outputs are valid 1 time unit after a change (combinational)
    // or just after the following rising edge (registered).
    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_apply);
`ifdef HALF_ADDER_REG_OUT_EN
            #6;
`else
            #1;
`endif
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty: got no entry, expected one");
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_w1_sum"}, {3'b000, s1}, {3'b000, e.es1});
                check({e.name, "_w1_count"}, {3'b000, c1}, {3'b000, e.ec1});
                check({e.name, "_w4_sum"}, s4, e.es4);
                check({e.name, "_w4_count"}, c4, e.ec4);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rs;
        logic [3:0] rc;
        logic [1:0] lane;
        n_tests = 0;
        n_fail  = 0;

        // Reset phase with 1+1 on every lane.
        sys_rst = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        a4 = 4'b1111;
        b4 = 4'b1111;
        #12;
`ifdef HALF_ADDER_REG_OUT_EN
        check("reset_hold_sum", s4, 4'b0000);
        check("reset_hold_count", c4, 4'b0000);
`else
        check("rst_ignored_sum", s4, 4'b0000);
        check("rst_ignored_count", c4, 4'b1111);
`endif
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
`ifdef HALF_ADDER_REG_OUT_EN
        check("post_release_pre_edge_count", {3'b000, c1}, 4'b0000);
        @(posedge sys_clk);
        #1;
        check("first_edge_sum", {3'b000, s1}, 4'b0000);
        check("first_edge_count", {3'b000, c1}, 4'b0001);
`else
        check("after_release_count", {3'b000, c1}, 4'b0001);
`endif

        // Directed vectors, hand-computed.
        apply(0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, "v00");
        apply(0, 1, 4'b1100, 4'b1010, 1, 0, 4'b0110, 4'b1000, "v01");
        apply(1, 0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b1111, "v10");
        apply(1, 1, 4'b1111, 4'b0000, 0, 1, 4'b1111, 4'b0000, "v11");
        apply(0, 1, 4'b0101, 4'b0011, 1, 0, 4'b0110, 4'b0001, "v0101_0011");
        apply(1, 1, 4'b1001, 4'b0110, 0, 1, 4'b1111, 4'b0000, "v1001_0110");
        apply(1, 0, 4'b0000, 4'b1111, 1, 0, 4'b1111, 4'b0000, "v0000_1111");

        // Random sweep against per-lane 2-bit arithmetic.
        for (int k = 0; k < 1000; k++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                lane  = {1'b0, ra[i]} + {1'b0, rb[i]};
                rs[i] = lane[0];
                rc[i] = lane[1];
            end
            apply(ra[0], rb[0], ra, rb, rs[0], rc[0], rs, rc, "rand");
        end

        @(negedge sys_clk);
        @(negedge sys_clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
        end

`ifdef HALF_ADDER_REG_OUT_EN
        // Async reset between edges with a settled sum=1.
        @(negedge sys_clk);
        a1 = 1'b1;
        b1 = 1'b0;
        @(posedge sys_clk);
        #1;
        check("settled_sum", {3'b000, s1}, 4'b0001);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_rst_sum", {3'b000, s1}, 4'b0000);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Input change between edges is not seen until the next edge.
        a1 = 1'b1;
        b1 = 1'b1;
        @(posedge sys_clk);
        #1;
        check("hold11_count", {3'b000, c1}, 4'b0001);
        @(negedge sys_clk);
        a1 = 1'b0;
        b1 = 1'b1;
        #1;
        check("between_edges_sum", {3'b000, s1}, 4'b0000);
        check("between_edges_count", {3'b000, c1}, 4'b0001);
        @(posedge sys_clk);
        #1;
        check("next_edge_sum", {3'b000, s1}, 4'b0001);
        check("next_edge_count", {3'b000, c1}, 4'b0000);
`else
        // Outputs follow inputs without any clock edge.
        @(posedge sys_clk);
        #1;
        a4 = 4'b0110;
        b4 = 4'b1100;
        #1;
        check("no_clock_sum", s4, 4'b1010);
        check("no_clock_count", c4, 4'b0100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
